// File: rtl/gpio_bank_if.sv
// gpio_bank_if: register bus between the J1a I/O decoder and one gpio_bank.
// The master drives select, strobe, address and write data. The bank returns
// combinational read data.
interface gpio_bank_if #(
   parameter int WIDTH = 8
);
   logic             cs;
   logic             we;
   logic [3:0]       addr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rd;

   modport master (output cs, output we, output addr, output wd, input rd);
   modport slave  (input cs, input we, input addr, input wd, output rd);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: WIDTH-pin GPIO bank for the J1a I/O space.
// It provides OUT/DIR registers with atomic SET/CLR/TGL writes and 2-flop
// input synchronisers. Rising and falling edges are captured per pin into a
// write-1-to-clear EDGE register, and a maskable interrupt is derived from it.
// Optional feature macro: GPIO_DEBOUNCE_EN inserts a per-pin stability
// counter of DB_CYCLES cycles between the synchroniser and IN.
module gpio_bank #(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             resetq,
   gpio_bank_if.slave       bus,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq
);

   localparam logic [3:0] A_OUT  = 4'd0;
   localparam logic [3:0] A_DIR  = 4'd1;
   localparam logic [3:0] A_IN   = 4'd2;
   localparam logic [3:0] A_SET  = 4'd3;
   localparam logic [3:0] A_CLR  = 4'd4;
   localparam logic [3:0] A_TGL  = 4'd5;
   localparam logic [3:0] A_ENR  = 4'd6;
   localparam logic [3:0] A_ENF  = 4'd7;
   localparam logic [3:0] A_EDGE = 4'd8;
   localparam logic [3:0] A_IEN  = 4'd9;

   // Out-of-range parameters elaborate this empty marker block so they are visible in the hierarchy.
   if (DB_CYCLES < 2 || WIDTH < 1 || WIDTH > 16) begin : g_param_out_of_range
   end

   logic [WIDTH-1:0] r_out, r_dir, r_enr, r_enf, r_ien, r_edge;
   logic [WIDTH-1:0] r_s1, r_s2, r_prev;
   logic [WIDTH-1:0] r_pin_out, r_pin_oe;
   logic             r_irq;

   logic             w_wr;
   logic [WIDTH-1:0] w_in, w_hit, w_clr, w_edge_next, w_rd;

   assign w_wr = bus.cs & bus.we;

   // Software-visible control registers; OUT has plain, OR, AND-NOT and XOR write ports.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_out <= '0;
         r_dir <= '0;
         r_enr <= '0;
         r_enf <= '0;
         r_ien <= '0;
      end else if (w_wr) begin
         case (bus.addr)
            A_OUT:   r_out <= bus.wd;
            A_SET:   r_out <= r_out | bus.wd;
            A_CLR:   r_out <= r_out & ~bus.wd;
            A_TGL:   r_out <= r_out ^ bus.wd;
            A_DIR:   r_dir <= bus.wd;
            A_ENR:   r_enr <= bus.wd;
            A_ENF:   r_enf <= bus.wd;
            A_IEN:   r_ien <= bus.wd;
            default: ;
         endcase
      end
   end

   // Pad drivers are retimed copies of OUT/DIR, so they lag a write by one cycle.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_pin_out <= '0;
         r_pin_oe  <= '0;
      end else begin
         r_pin_out <= r_out;
         r_pin_oe  <= r_dir;
      end
   end

   assign pin_out = r_pin_out;
   assign pin_oe  = r_pin_oe;

   // Two-flop synchroniser for asynchronous pads, plus the one-cycle-old IN used for edge detection.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= '0;
      end else begin
         r_s1   <= pin_in;
         r_s2   <= r_s1;
         r_prev <= w_in;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DB_CYCLES);

   logic [CNT_W-1:0] r_db_cnt [WIDTH];
   logic [WIDTH-1:0] r_db_in;

   // IN follows s2 only after s2 has disagreed with it for DB_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_db_in <= '0;
         for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] != r_db_in[i]) begin
               if (r_db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                  r_db_in[i]  <= r_s2[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   assign w_in = r_db_in;
`else
   assign w_in = r_s2;
`endif

   // A new edge outranks a simultaneous W1C on the same bit, so no event is lost.
   assign w_hit       = (r_enr & w_in & ~r_prev) | (r_enf & ~w_in & r_prev);
   assign w_clr       = (w_wr && bus.addr == A_EDGE) ? bus.wd : '0;
   assign w_edge_next = (r_edge & ~w_clr) | w_hit;

   // Edge capture register, with irq computed from the next EDGE value so it tracks EDGE on the same edge.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_edge <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_edge <= w_edge_next;
         r_irq  <= |(w_edge_next & r_ien);
      end
   end

   assign irq = r_irq;

   // Side-effect-free read mux; the SET/CLR/TGL aliases read back OUT.
   always_comb begin
      w_rd = '0;
      if (bus.cs) begin
         case (bus.addr)
            A_OUT, A_SET, A_CLR, A_TGL: w_rd = r_out;
            A_DIR:                      w_rd = r_dir;
            A_IN:                       w_rd = w_in;
            A_ENR:                      w_rd = r_enr;
            A_ENF:                      w_rd = r_enf;
            A_EDGE:                     w_rd = r_edge;
            A_IEN:                      w_rd = r_ien;
            default:                    w_rd = '0;
         endcase
      end
   end

   assign bus.rd = w_rd;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed test of gpio_bank with WIDTH=8.
// When GPIO_DEBOUNCE_EN is defined, DB_CYCLES=4 is used and the debounce scenario replaces the
// undebounced timing scenarios.
module tb_gpio_bank;

   logic       clk;
   logic       resetq;
   logic [7:0] pin_in;
   logic [7:0] pin_out;
   logic [7:0] pin_oe;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_bank_if #(.WIDTH(8)) bus ();

   gpio_bank #(.WIDTH(8), .DB_CYCLES(4)) dut (
      .clk     (clk),
      .resetq  (resetq),
      .bus     (bus),
      .pin_in  (pin_in),
      .pin_out (pin_out),
      .pin_oe  (pin_oe),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.cs   = 1'b1;
      bus.we   = 1'b1;
      bus.addr = a;
      bus.wd   = d;
      @(posedge clk);
      #1;
      bus.cs = 1'b0;
      bus.we = 1'b0;
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
      bus.cs   = 1'b1;
      bus.we   = 1'b0;
      bus.addr = a;
      #1;
      d = bus.rd;
      bus.cs = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      resetq = 1'b0;
      pin_in = 8'h00;
      bus.cs = 1'b0;
      bus.we = 1'b0;
      bus.addr = 4'd0;
      bus.wd = 8'h00;
      tick(3);
      n_checks++;
      if (pin_oe !== 8'h00) begin n_fail++; $display("FAIL reset_pin_oe got=%h exp=00", pin_oe); end
      n_checks++;
      if (pin_out !== 8'h00) begin n_fail++; $display("FAIL reset_pin_out got=%h exp=00", pin_out); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
      @(negedge clk);
      resetq = 1'b1;
      tick(1);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL reset_edge got=%h exp=00", v); end
      rd_reg(4'd0, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h exp=00", v); end
      rd_reg(4'd1, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL reset_dir got=%h exp=00", v); end
      n_checks++;
      if (pin_oe !== 8'h00 || pin_out !== 8'h00 || irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_release_outputs oe=%h out=%h irq=%b exp=00/00/0", pin_oe, pin_out, irq);
      end
   endtask

   task automatic test_atomic();
      logic [3:0] a_tab [4] = '{4'd0, 4'd3, 4'd4, 4'd5};
      logic [7:0] d_tab [4] = '{8'hA5, 8'h0F, 8'h81, 8'hFF};
      logic [7:0] e_tab [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
      logic [7:0] prev = 8'h00;
      logic [7:0] v;
      for (int i = 0; i < 4; i++) begin
         wr(a_tab[i], d_tab[i]);
         rd_reg(4'd0, v);
         n_checks++;
         if (v !== e_tab[i]) begin n_fail++; $display("FAIL atomic_out[%0d] got=%h exp=%h", i, v, e_tab[i]); end
         n_checks++;
         if (pin_out !== prev) begin n_fail++; $display("FAIL atomic_pin_lag[%0d] got=%h exp=%h", i, pin_out, prev); end
         tick(1);
         n_checks++;
         if (pin_out !== e_tab[i]) begin n_fail++; $display("FAIL atomic_pin_out[%0d] got=%h exp=%h", i, pin_out, e_tab[i]); end
         prev = e_tab[i];
      end
      rd_reg(4'd3, v);
      n_checks++;
      if (v !== 8'hD1) begin n_fail++; $display("FAIL set_alias_read got=%h exp=D1", v); end
      wr(4'd1, 8'h3C);
      n_checks++;
      if (pin_oe !== 8'h00) begin n_fail++; $display("FAIL dir_pin_lag got=%h exp=00", pin_oe); end
      tick(1);
      n_checks++;
      if (pin_oe !== 8'h3C) begin n_fail++; $display("FAIL dir_pin_oe got=%h exp=3C", pin_oe); end
      wr(4'd10, 8'hFF);
      rd_reg(4'd10, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got=%h exp=00", v); end
      rd_reg(4'd0, v);
      n_checks++;
      if (v !== 8'hD1) begin n_fail++; $display("FAIL unmapped_write_ignored got=%h exp=D1", v); end
      bus.cs = 1'b0;
      bus.addr = 4'd0;
      #1;
      n_checks++;
      if (bus.rd !== 8'h00) begin n_fail++; $display("FAIL rd_without_cs got=%h exp=00", bus.rd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      wr(4'd0, 8'hF0);
      wr(4'd3, 8'h01);
      wr(4'd4, 8'h10);
      wr(4'd5, 8'hFF);
      rd_reg(4'd0, v);
      n_checks++;
      if (v !== 8'h1E) begin n_fail++; $display("FAIL b2b_out got=%h exp=1E", v); end
      n_checks++;
      if (pin_out !== 8'hE1) begin n_fail++; $display("FAIL b2b_pin_lag got=%h exp=E1", pin_out); end
      tick(1);
      n_checks++;
      if (pin_out !== 8'h1E) begin n_fail++; $display("FAIL b2b_pin_out got=%h exp=1E", pin_out); end
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic test_debounce();
      logic [7:0] v;
      pin_in = 8'h00;
      tick(3);
      pin_in = 8'h01;
      tick(3);
      pin_in = 8'h00;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         rd_reg(4'd2, v);
         n_checks++;
         if (v !== 8'h00) begin n_fail++; $display("FAIL db_pulse_ignored[%0d] got=%h exp=00", i, v); end
      end
      pin_in = 8'h01;
      tick(5);
      rd_reg(4'd2, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL db_before_rise got=%h exp=00", v); end
      tick(1);
      rd_reg(4'd2, v);
      n_checks++;
      if (v !== 8'h01) begin n_fail++; $display("FAIL db_rise got=%h exp=01", v); end
   endtask
`else
   task automatic test_input_latency();
      logic [7:0] v;
      pin_in = 8'h5A;
      tick(1);
      rd_reg(4'd2, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL in_latency_t1 got=%h exp=00", v); end
      tick(1);
      rd_reg(4'd2, v);
      n_checks++;
      if (v !== 8'h5A) begin n_fail++; $display("FAIL in_latency_t2 got=%h exp=5A", v); end
   endtask

   task automatic test_edge_irq();
      logic [7:0] v;
      pin_in = 8'h02;
      tick(4);
      wr(4'd6, 8'h01);
      wr(4'd7, 8'h02);
      wr(4'd9, 8'h03);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h00 || irq !== 1'b0) begin n_fail++; $display("FAIL edge_no_level_capture edge=%h irq=%b exp=00/0", v, irq); end
      pin_in = 8'h03;
      tick(2);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL edge_rise_early got=%h exp=00", v); end
      tick(1);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h01 || irq !== 1'b1) begin n_fail++; $display("FAIL edge_rise edge=%h irq=%b exp=01/1", v, irq); end
      pin_in = 8'h01;
      tick(3);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h03 || irq !== 1'b1) begin n_fail++; $display("FAIL edge_fall edge=%h irq=%b exp=03/1", v, irq); end
      wr(4'd8, 8'h01);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h02 || irq !== 1'b1) begin n_fail++; $display("FAIL edge_w1c_bit0 edge=%h irq=%b exp=02/1", v, irq); end
      wr(4'd8, 8'h02);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h00 || irq !== 1'b0) begin n_fail++; $display("FAIL edge_w1c_bit1 edge=%h irq=%b exp=00/0", v, irq); end
   endtask

   task automatic test_w1c_collision();
      logic [7:0] v;
      pin_in = 8'h00;
      tick(4);
      pin_in = 8'h01;
      tick(2);
      wr(4'd8, 8'h01);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h01 || irq !== 1'b1) begin n_fail++; $display("FAIL w1c_collision edge=%h irq=%b exp=01/1", v, irq); end
      wr(4'd9, 8'h00);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_lag got=%b exp=1", irq); end
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_clear got=%b exp=0", irq); end
      wr(4'd8, 8'hFF);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL w1c_all got=%h exp=00", v); end
   endtask

   task automatic test_output_pin_capture();
      logic [7:0] v;
      wr(4'd1, 8'hFF);
      wr(4'd6, 8'h04);
      pin_in = 8'h05;
      tick(3);
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h04) begin n_fail++; $display("FAIL capture_on_output got=%h exp=04", v); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b exp=0", irq); end
      wr(4'd8, 8'h04);
   endtask

   task automatic test_async_reset();
      logic [7:0] v;
      wr(4'd6, 8'h05);
      wr(4'd9, 8'h01);
      wr(4'd1, 8'hAA);
      pin_in = 8'h04;
      tick(3);
      pin_in = 8'h05;
      tick(3);
      n_checks++;
      if (irq !== 1'b1 || pin_oe !== 8'hAA) begin n_fail++; $display("FAIL async_pre irq=%b oe=%h exp=1/AA", irq, pin_oe); end
      #2;
      resetq = 1'b0;
      #1;
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq got=%b exp=0", irq); end
      n_checks++;
      if (pin_out !== 8'h00 || pin_oe !== 8'h00) begin n_fail++; $display("FAIL async_pins out=%h oe=%h exp=00/00", pin_out, pin_oe); end
      rd_reg(4'd0, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL async_out_reg got=%h exp=00", v); end
      rd_reg(4'd8, v);
      n_checks++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL async_edge_reg got=%h exp=00", v); end
      @(negedge clk);
      resetq = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_atomic();
      test_back_to_back();
`ifdef GPIO_DEBOUNCE_EN
      test_debounce();
`else
      test_input_latency();
      test_edge_irq();
      test_w1c_collision();
      test_output_pin_capture();
      test_async_reset();
`endif
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
